bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Round-robin arbiter sharing one Wishbone-classic slave bus (cyc/we/adr/dat/sel/ack) between up to NMASTERS bus masters.
- Typical masters: bexkat1 CPU, DMA engine, video fetch.
- Sits between the masters and the system address decoder.
- Grant is held for a whole bus cycle (cyc-locked), so multi-beat CPU sequences are never split.

Parameters:
NMASTERS, 3, number of requesting masters (2..8)
AW, 32, address width
DW, 32, data width; select width is DW/8

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset, asynchronous, active-low
m_cyc_i  in  NMASTERS  per-master cycle request
m_we_i  in  NMASTERS  per-master write enable
m_adr_i  in  NMASTERS*AW  packed addresses, master k at [k*AW +: AW]
m_dat_i  in  NMASTERS*DW  packed write data
m_sel_i  in  NMASTERS*DW/8  packed byte selects
m_ack_o  out  NMASTERS  per-master ack
m_err_o  out  NMASTERS  per-master error (timeout only; see Optional Feature)
m_dat_o  out  DW  read data broadcast to all masters
s_cyc_o  out  1  slave cycle
s_we_o  out  1  slave write enable
s_adr_o  out  AW  slave address
s_dat_o  out  DW  slave write data
s_sel_o  out  DW/8  slave byte selects
s_ack_i  in  1  slave ack
s_dat_i  in  DW  slave read data
grant_o  out  NMASTERS  one-hot current owner, 0 when idle

Behaviour:
- Reset (rst_ni low, async):
  - FSM in IDLE; grant_o=0.
  - s_cyc_o=0, s_we_o=0, s_adr_o=0, s_dat_o=0, s_sel_o=0.
  - m_ack_o=0, m_err_o=0.
  - Round-robin pointer = NMASTERS-1, so master 0 wins first.
- IDLE:
  - If any m_cyc_i is set, select the first requester searching from pointer+1 upward, wrapping modulo NMASTERS.
  - Register that master's one-hot grant and go to OWNED on the next edge: 1-cycle arbitration latency.
  - pointer <= granted index.
  - No requests: stay IDLE, all slave outputs 0.
- OWNED:
  - s_cyc_o/s_we_o/s_adr_o/s_dat_o/s_sel_o are combinational muxes of the owner's inputs, gated by grant.
  - m_ack_o[owner] = s_ack_i; all other m_ack_o bits are 0.
  - m_dat_o = s_dat_i at all times.
- Release: owner deasserts m_cyc_i → s_cyc_o drops the same cycle (combinational); FSM returns to IDLE next edge.
  - The IDLE cycle is mandatory, so back-to-back grants always have one dead cycle between them.
- Non-owner requests are ignored while OWNED; those masters stall with ack=0.
- s_ack_i while IDLE is ignored (no ack routed).
- Simultaneous requests from all masters: grants rotate 0,1,2,0,...
- A single repeat requester re-wins after one IDLE cycle if no one else requests.
- Reset asserted mid-cycle: grant and s_cyc_o drop immediately (async); no ack is delivered.
- Pointer arithmetic wraps NMASTERS-1 → 0. For non-power-of-2 NMASTERS, indices >= NMASTERS are never selected.

Optional Feature:
- Macro: BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - 8-bit watchdog counter cleared on entry to OWNED and on every s_ack_i.
  - Increments each OWNED cycle without s_ack_i.
  - On reaching 255:
    - assert m_err_o[owner] for exactly one cycle;
    - force s_cyc_o=0 that cycle;
    - return to IDLE regardless of m_cyc_i;
    - advance the pointer past the owner.
  - The owner must drop m_cyc_i on seeing err. If it still holds m_cyc_i, it re-enters arbitration normally.
- Undefined: no counter; m_err_o tied to 0; a hung slave holds the bus indefinitely.

Test Plan:
- Reset then only master 0 requests: write adr 0x00001000, dat 0xdeadbeef, sel 0xf; slave acks 2 cycles later → s_adr_o=0x00001000 from cycle 1 after request, m_ack_o=3'b001 for one cycle, grant_o returns to 0 one cycle after m_cyc_i[0] drops.
- All three masters hold m_cyc_i continuously, slave acks every cycle, each master drops cyc after its ack → grant_o sequence 001,000,010,000,100,000,001.
- Master 1 owns with 4-beat read (cyc held, 4 acks, s_dat_i=1,2,3,4); master 2 requests mid-burst → master 2 not granted until master 1 drops cyc; m_ack_o[2]=0 throughout; master 1 sees data 1..4.
- rst_ni pulsed low while master 0 owns with s_ack_i pending → s_cyc_o, grant_o, m_ack_o all 0 immediately; after release, master 0 wins first again.
- BUS_ARBITER_TIMEOUT_EN defined, master 2 owns, slave never acks → m_err_o=3'b100 for one cycle 255 cycles after grant; s_cyc_o=0 that cycle; master 0 requesting is granted next.
- BUS_ARBITER_TIMEOUT_EN undefined, same stimulus → m_err_o stays 0; grant_o remains 3'b100 after 1000 cycles.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Shared Wishbone-classic bus bundle for bus_arbiter: NMASTERS request ports plus the single slave-side port.
// The master modport is the arbiter's view (it masters the shared slave bus); slave is the environment's view.
interface bus_arbiter_if #(
    parameter int NMASTERS = 3,
    parameter int AW       = 32,
    parameter int DW       = 32
);
    logic [NMASTERS-1:0]        m_cyc_i;
    logic [NMASTERS-1:0]        m_we_i;
    logic [NMASTERS*AW-1:0]     m_adr_i;
    logic [NMASTERS*DW-1:0]     m_dat_i;
    logic [NMASTERS*DW/8-1:0]   m_sel_i;
    logic [NMASTERS-1:0]        m_ack_o;
    logic [NMASTERS-1:0]        m_err_o;
    logic [DW-1:0]              m_dat_o;
    logic                       s_cyc_o;
    logic                       s_we_o;
    logic [AW-1:0]              s_adr_o;
    logic [DW-1:0]              s_dat_o;
    logic [DW/8-1:0]            s_sel_o;
    logic                       s_ack_i;
    logic [DW-1:0]              s_dat_i;
    logic [NMASTERS-1:0]        grant_o;

    modport master (
        input  m_cyc_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
        output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, grant_o
    );

    modport slave (
        output m_cyc_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
        input  m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, grant_o
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin, cyc-locked arbiter sharing one Wishbone-classic slave among NMASTERS masters.
// Optional bus watchdog enabled by defining BUS_ARBITER_TIMEOUT_EN.

// Per-master gating: contributes the master's signals only while it holds the grant.
module bus_arbiter_lane #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            gnt,
    input  logic            cyc,
    input  logic            we,
    input  logic [AW-1:0]   adr,
    input  logic [DW-1:0]   dat,
    input  logic [DW/8-1:0] sel,
    input  logic            s_ack,
    input  logic            tmo,
    output logic            g_cyc,
    output logic            g_we,
    output logic [AW-1:0]   g_adr,
    output logic [DW-1:0]   g_dat,
    output logic [DW/8-1:0] g_sel,
    output logic            ack,
    output logic            err
);
    assign g_cyc = gnt & cyc & ~tmo;
    assign g_we  = gnt & we;
    assign g_adr = gnt ? adr : '0;
    assign g_dat = gnt ? dat : '0;
    assign g_sel = gnt ? sel : '0;
    // An ack is only meaningful to a master still running its cycle.
    assign ack   = g_cyc & s_ack;
    assign err   = gnt & tmo;
endmodule

module bus_arbiter #(
    parameter int NMASTERS = 3,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    bus_arbiter_if.master bus
);
    localparam int SW = DW / 8;
    localparam int IW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t              state_q, state_d;
    logic [NMASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic                tmo;
    logic                owner_cyc;
    logic                win_found;
    logic [IW-1:0]       win_idx;
    logic [IW-1:0]       cand_idx;
    int                  cand;

    logic [NMASTERS-1:0]           l_cyc, l_we, l_ack, l_err;
    logic [NMASTERS-1:0][AW-1:0]   l_adr;
    logic [NMASTERS-1:0][DW-1:0]   l_dat;
    logic [NMASTERS-1:0][SW-1:0]   l_sel;
    logic [AW-1:0]                 s_adr;
    logic [DW-1:0]                 s_dat;
    logic [SW-1:0]                 s_sel;

    generate
        for (genvar g = 0; g < NMASTERS; g++) begin : g_lane
            bus_arbiter_lane #(.AW(AW), .DW(DW)) u_lane (
                .gnt   (grant_q[g]),
                .cyc   (bus.m_cyc_i[g]),
                .we    (bus.m_we_i[g]),
                .adr   (bus.m_adr_i[g*AW +: AW]),
                .dat   (bus.m_dat_i[g*DW +: DW]),
                .sel   (bus.m_sel_i[g*SW +: SW]),
                .s_ack (bus.s_ack_i),
                .tmo   (tmo),
                .g_cyc (l_cyc[g]),
                .g_we  (l_we[g]),
                .g_adr (l_adr[g]),
                .g_dat (l_dat[g]),
                .g_sel (l_sel[g]),
                .ack   (l_ack[g]),
                .err   (l_err[g])
            );
        end
    endgenerate

    // Grant is one-hot, so OR-ing the gated lanes is the mux.
    always_comb begin
        s_adr = '0;
        s_dat = '0;
        s_sel = '0;
        for (int k = 0; k < NMASTERS; k++) begin
            s_adr = s_adr | l_adr[k];
            s_dat = s_dat | l_dat[k];
            s_sel = s_sel | l_sel[k];
        end
    end

    assign bus.s_cyc_o = |l_cyc;
    assign bus.s_we_o  = |l_we;
    assign bus.s_adr_o = s_adr;
    assign bus.s_dat_o = s_dat;
    assign bus.s_sel_o = s_sel;
    assign bus.m_ack_o = l_ack;
    assign bus.m_err_o = l_err;
    assign bus.m_dat_o = bus.s_dat_i;
    assign bus.grant_o = grant_q;

    assign owner_cyc = |(bus.m_cyc_i & grant_q);

    // First requester strictly after the pointer, wrapping modulo NMASTERS.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= NMASTERS; i++) begin
            cand     = (int'(ptr_q) + i) % NMASTERS;
            cand_idx = IW'(cand);
            if (!win_found && bus.m_cyc_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = OWNED;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    ptr_d            = win_idx;
                end
            end
            OWNED: begin
                if (!owner_cyc || tmo) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= IW'(NMASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef BUS_ARBITER_TIMEOUT_EN
    logic [7:0] wd_q;

    // Held at zero outside OWNED, so every ownership starts from a fresh count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            wd_q <= '0;
        else if (state_q != OWNED || bus.s_ack_i)
            wd_q <= '0;
        else
            wd_q <= wd_q + 8'd1;
    end

    assign tmo = (state_q == OWNED) && (wd_q == 8'hFF);
`else
    assign tmo = 1'b0;
`endif
endmodule
